encoder8to3: RTL and testbench

ENCODER8TO3 -- requirements
Module: encoder8to3

---
 rtl/encoder_pkg.sv | 13 +
 rtl/encoder8to3_pick.sv | 32 +++
 rtl/encoder8to3.sv | 87 ++++++++
 tb/tb_encoder8to3.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared widths, state encoding and priority-mode constants for encoder8to3
package encoder_pkg;
   localparam int CODE_W = 3;
   localparam int REQ_W  = 8;

   localparam bit FIXED = 1'b0;
   localparam bit RR    = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;
endpackage

// File: rtl/encoder8to3_pick.sv
// rtl/encoder8to3_pick.sv - combinational priority pick over the pending vector
module encoder8to3_pick
   import encoder_pkg::*;
(
   input  logic [REQ_W-1:0]  pending,
   input  logic [CODE_W-1:0] start,
   input  logic              mode,
   output logic              found,
   output logic [CODE_W-1:0] index,
   output logic [REQ_W-1:0]  mask
);

   logic [CODE_W-1:0] base;
   logic [CODE_W-1:0] idx;

   always_comb begin
      base  = (mode == RR) ? start : '0;
      found = 1'b0;
      index = '0;
      idx   = '0;
      // Walk offsets from far to near so the nearest set bit after base wins.
      for (int k = REQ_W - 1; k >= 0; k--) begin
         idx = base + CODE_W'(k);
         if (pending[idx]) begin
            found = 1'b1;
            index = idx;
         end
      end
      mask = found ? (REQ_W'(1) << index) : '0;
   end

endmodule

// File: rtl/encoder8to3.sv
// rtl/encoder8to3.sv - pending-request encoder with one-entry valid/ready output stage
module encoder8to3
   import encoder_pkg::*;
#(
   parameter int RR_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REQ_W-1:0]  req,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [CODE_W-1:0] code,
   output logic [REQ_W-1:0]  onehot,
   output logic [REQ_W-1:0]  pending,
   output logic [7:0]        drop_cnt
);

   state_t            state;
   state_t            state_next;
   logic [CODE_W-1:0] last_code;
   logic              found;
   logic [CODE_W-1:0] pick_idx;
   logic [REQ_W-1:0]  pick_mask;
   logic              load;
   logic              xfer;
   logic [REQ_W-1:0]  load_mask;
   logic              drop_any;

   encoder8to3_pick u_pick (
      .pending (pending),
      .start   (last_code + CODE_W'(1)),
      .mode    ((RR_MODE != 0) ? RR : FIXED),
      .found   (found),
      .index   (pick_idx),
      .mask    (pick_mask)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (found) state_next = FULL;
         FULL:    if (out_ready && !found) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      xfer      = (state == FULL) && out_ready;
      load      = found && ((state == EMPTY) || out_ready);
      load_mask = load ? pick_mask : '0;
      // A request on a bit that stays pending is merged and counted as dropped.
      drop_any  = |(req & pending & ~load_mask);
   end

   assign out_valid = (state == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         code      <= '0;
         onehot    <= '0;
         drop_cnt  <= '0;
         last_code <= CODE_W'(7);
      end else begin
         pending <= (pending & ~load_mask) | req;
         if (load) begin
            code      <= pick_idx;
            onehot    <= pick_mask;
            last_code <= pick_idx;
         end else if (xfer) begin
            onehot <= '0;
         end
         if (drop_any && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_encoder8to3.sv
// tb/tb_encoder8to3.sv - directed self-checking bench for encoder8to3 in fixed and round-robin modes
module tb_encoder8to3;

   logic       clk;
   logic       rst;
   logic [7:0] f_req;
   logic       f_ready;
   logic       f_valid;
   logic [2:0] f_code;
   logic [7:0] f_onehot;
   logic [7:0] f_pending;
   logic [7:0] f_drop;
   logic [7:0] r_req;
   logic       r_ready;
   logic       r_valid;
   logic [2:0] r_code;
   logic [7:0] r_onehot;
   logic [7:0] r_pending;
   logic [7:0] r_drop;

   int n_checks;
   int n_errors;

   encoder8to3 #(.RR_MODE(0)) u_fixed (
      .clk       (clk),
      .rst       (rst),
      .req       (f_req),
      .out_ready (f_ready),
      .out_valid (f_valid),
      .code      (f_code),
      .onehot    (f_onehot),
      .pending   (f_pending),
      .drop_cnt  (f_drop)
   );

   encoder8to3 #(.RR_MODE(1)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .req       (r_req),
      .out_ready (r_ready),
      .out_valid (r_valid),
      .code      (r_code),
      .onehot    (r_onehot),
      .pending   (r_pending),
      .drop_cnt  (r_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      f_req    = '0;
      f_ready  = 1'b0;
      r_req    = '0;
      r_ready  = 1'b0;
      tick();
      check("rst_valid", f_valid, 0);
      check("rst_code", f_code, 0);
      check("rst_onehot", f_onehot, 0);
      check("rst_pending", f_pending, 0);
      check("rst_drop", f_drop, 0);

      // fixed priority: 1010_0100 drains as 2, 5, 7
      rst = 1'b0;
      f_ready = 1'b1;
      f_req = 8'hA4;
      tick();
      check("fx_pend_a4", f_pending, 8'hA4);
      check("fx_latency_valid", f_valid, 0);
      f_req = 8'h00;
      tick();
      check("fx_c2_valid", f_valid, 1);
      check("fx_c2", f_code, 2);
      check("fx_c2_onehot", f_onehot, 8'h04);
      check("fx_c2_pend", f_pending, 8'hA0);
      tick();
      check("fx_c5", f_code, 5);
      check("fx_c5_onehot", f_onehot, 8'h20);
      tick();
      check("fx_c7", f_code, 7);
      check("fx_c7_pend", f_pending, 8'h00);
      tick();
      check("fx_drain_valid", f_valid, 0);
      check("fx_drain_onehot", f_onehot, 8'h00);

      // backpressure with code 3 held
      f_ready = 1'b0;
      f_req = 8'h08;
      tick();
      f_req = 8'h00;
      tick();
      check("bp_load_valid", f_valid, 1);
      check("bp_load_code", f_code, 3);
      f_req = 8'h08;
      for (int i = 0; i < 5; i++) begin
         tick();
         f_req = 8'h00;
         check("bp_hold_code", f_code, 3);
         check("bp_hold_onehot", f_onehot, 8'h08);
         check("bp_hold_valid", f_valid, 1);
         check("bp_hold_drop", f_drop, 0);
      end
      check("bp_pend_merge", f_pending, 8'h08);
      f_req = 8'h08;
      tick();
      f_req = 8'h00;
      check("bp_drop_one", f_drop, 1);
      f_ready = 1'b1;
      tick();
      check("bp_reissue_valid", f_valid, 1);
      check("bp_reissue_code", f_code, 3);
      check("bp_reissue_pend", f_pending, 0);
      tick();
      check("bp_empty", f_valid, 0);

      // request on a bit in the same cycle it is loaded
      f_req = 8'h01;
      tick();
      check("sim_pend", f_pending, 8'h01);
      tick();
      f_req = 8'h00;
      check("sim_first_code", f_code, 0);
      check("sim_first_valid", f_valid, 1);
      check("sim_pend_kept", f_pending, 8'h01);
      check("sim_no_drop", f_drop, 1);
      tick();
      check("sim_second_code", f_code, 0);
      check("sim_second_valid", f_valid, 1);
      check("sim_pend_clear", f_pending, 0);
      check("sim_drop_same", f_drop, 1);
      tick();
      check("sim_empty", f_valid, 0);

      // drop counter saturation
      f_ready = 1'b0;
      f_req = 8'h01;
      for (int i = 0; i < 300; i++) tick();
      check("sat_ff", f_drop, 8'hFF);
      tick();
      check("sat_hold", f_drop, 8'hFF);

      // reset while FULL with F0 pending
      f_req = 8'h00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      f_req = 8'hF1;
      tick();
      f_req = 8'h00;
      tick();
      check("rfull_valid", f_valid, 1);
      check("rfull_pend", f_pending, 8'hF0);
      rst = 1'b1;
      f_req = 8'h0F;
      tick();
      check("rmid_valid", f_valid, 0);
      check("rmid_code", f_code, 0);
      check("rmid_onehot", f_onehot, 0);
      check("rmid_pend", f_pending, 0);
      check("rmid_drop", f_drop, 0);
      rst = 1'b0;
      f_req = 8'h00;
      tick();
      check("rpost_pend", f_pending, 0);
      check("rpost_valid", f_valid, 0);
      f_req = 8'h02;
      tick();
      f_req = 8'h00;
      check("rpost_sample", f_pending, 8'h02);

      // round-robin with all requests held for 10 cycles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rr_rst_valid", r_valid, 0);
      check("rr_rst_drop", r_drop, 0);
      r_ready = 1'b1;
      r_req = 8'hFF;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("rr_drop_step", r_drop, c);
         if (c >= 1) begin
            check("rr_code", r_code, (c - 1) % 8);
            check("rr_valid", r_valid, 1);
         end
      end
      r_req = 8'h00;
      tick();
      check("rr_code_tenth", r_code, 1);
      check("rr_pend_fd", r_pending, 8'hFD);
      for (int k = 2; k <= 8; k++) begin
         tick();
         check("rr_wrap_code", r_code, k % 8);
         check("rr_wrap_onehot", r_onehot, 8'h01 << (k % 8));
      end
      tick();
      check("rr_drained", r_valid, 0);
      check("rr_drop_final", r_drop, 9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
